// File: rtl/opseq_pkg.sv
// Shared types and widths for the operand sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package opseq_pkg;
  localparam int OPW  = 3;
  localparam int SUMW = 4;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_X = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/operand_sequencer_load_pulse.sv
// Turns the asynchronous load button level into one clk-wide pulse per press.
// Latency: pulse in the 3rd cycle after load rises (debounce off), or after DEBOUNCE_CYCLES synced-high cycles.
// Backpressure: none; a press is either pulsed or ignored. Debounce: OPERAND_SEQUENCER_DEBOUNCE_EN.
module load_pulse #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic pulse
);

  logic sync1;
  logic sync2;

  // Reject unusable debounce lengths at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 15) begin : g_bad_cfg
    $error("load_pulse: DEBOUNCE_CYCLES must be 2..15");
  end

  // Two-flop synchroniser for the button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= load;
      sync2 <= sync1;
    end
  end

`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
  localparam logic [3:0] RUN_LAST = 4'(DEBOUNCE_CYCLES - 1);

  // run_cnt counts prior consecutive high cycles; fired blocks repeats until the button is seen low.
  logic [3:0] run_cnt;
  logic       fired;

  assign pulse = sync2 & ~fired & (run_cnt == RUN_LAST);

  // Count the high run; any low cycle restarts the count and re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= 4'd0;
      fired   <= 1'b0;
    end else if (!sync2) begin
      run_cnt <= 4'd0;
      fired   <= 1'b0;
    end else begin
      if (run_cnt != RUN_LAST) run_cnt <= run_cnt + 4'd1;
      if (pulse) fired <= 1'b1;
    end
  end
`else
  logic sync2_q;

  assign pulse = sync2 & ~sync2_q;

  // Delay flop for rising-edge detection of the synced level.
  always_ff @(posedge clk) begin
    if (rst) sync2_q <= 1'b0;
    else     sync2_q <= sync2;
  end
`endif

endmodule

// File: rtl/operand_sequencer.sv
// Collects two switch operands by button presses, presents them to an adder and captures the sum.
// Latency: operand lands 3 cycles after load rises (more with OPERAND_SEQUENCER_DEBOUNCE_EN); sum captured on the op_ready cycle.
// Backpressure: holds x/y and op_valid in VALID until op_ready; presses are ignored meanwhile.
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  sw,
  input  logic            load,
  input  logic            clear,
  input  logic            op_ready,
  input  logic [SUMW-1:0] z_in,
  output logic [OPW-1:0]  x,
  output logic [OPW-1:0]  y,
  output logic            op_valid,
  output logic [SUMW-1:0] result,
  output logic            result_valid,
  output logic [1:0]      state,
  output logic [CNTW-1:0] op_count
);

  state_t st;
  logic   press;

  load_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_pulse (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .pulse(press)
  );

  assign op_valid = (st == VALID);
  assign state    = st;

  // Sequencer: clear beats any press or capture; result and op_count survive clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      x            <= '0;
      y            <= '0;
      result       <= '0;
      op_count     <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear) begin
        st <= IDLE;
        x  <= '0;
        y  <= '0;
      end else begin
        case (st)
          IDLE: if (press) begin
            x  <= sw;
            st <= GOT_X;
          end
          GOT_X: if (press) begin
            y  <= sw;
            st <= VALID;
          end
          VALID: if (op_ready) begin
            result       <= z_in;
            op_count     <= op_count + CNTW'(1);
            result_valid <= 1'b1;
            st           <= DONE;
          end
          DONE: if (press) begin
            x  <= sw;
            y  <= '0;
            st <= GOT_X;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomised self-checking bench for operand_sequencer against an event-level model.
// Latency: press latency checked cycle-exactly in the basic scenario.
// Backpressure: op_ready held low with extra presses to confirm operands hold.
module tb_operand_sequencer;
  localparam int DEB  = 4;
`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
  localparam int PRESS_LAT = 2 + DEB;
`else
  localparam int PRESS_LAT = 3;
`endif
  localparam int HOLD = DEB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw = 3'd0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic       op_ready = 1'b0;
  logic [3:0] z_in = 4'd0;
  logic [2:0] x, y;
  logic       op_valid;
  logic [3:0] result;
  logic       result_valid;
  logic [1:0] state;
  logic [3:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_seen  = 0;

  // Event-level model of what the sequencer should hold.
  int         m_state;
  logic [2:0] m_x, m_y;
  logic [3:0] m_res;
  int         m_cnt;

  operand_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .load(load), .clear(clear),
    .op_ready(op_ready), .z_in(z_in), .x(x), .y(y), .op_valid(op_valid),
    .result(result), .result_valid(result_valid), .state(state), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) rv_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 3'd0; m_y = 3'd0; m_res = 4'd0; m_cnt = 0;
  endtask

  task automatic model_press(input logic [2:0] v);
    case (m_state)
      0: begin m_x = v; m_state = 1; end
      1: begin m_y = v; m_state = 2; end
      3: begin m_x = v; m_y = 3'd0; m_state = 1; end
      default: ;
    endcase
  endtask

  task automatic model_capture(input logic [3:0] z);
    if (m_state == 2) begin
      m_res = z; m_cnt = (m_cnt + 1) % 16; m_state = 3;
    end
  endtask

  task automatic model_clear();
    m_state = 0; m_x = 3'd0; m_y = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; clear = 1'b0; op_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic do_press(input logic [2:0] v);
    sw = v; load = 1'b1;
    repeat (HOLD) tick();
    load = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    int rv0;
    sw = 3'd7; load = 1'b1; clear = 1'b1; op_ready = 1'b1; z_in = 4'd15;
    rst = 1'b1;
    repeat (2) tick();
    model_reset();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (x !== 3'd0 || y !== 3'd0) begin n_fail++; $display("FAIL reset_xy: got %0d/%0d want 0/0", x, y); end
    n_checks++; if (result !== 4'd0 || op_count !== 4'd0) begin n_fail++; $display("FAIL reset_res_cnt: got %0d/%0d want 0/0", result, op_count); end
    n_checks++; if (result_valid !== 1'b0 || op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %0b/%0b want 0/0", result_valid, op_valid); end
    rv0 = rv_seen;
    rst = 1'b0; load = 1'b0; clear = 1'b0; op_ready = 1'b0;
    repeat (6) tick();
    n_checks++; if (state !== 2'd0 || x !== 3'd0 || rv_seen != rv0) begin n_fail++; $display("FAIL reset_release: state %0d x %0d pulses %0d want 0 0 0", state, x, rv_seen - rv0); end
  endtask

  task automatic test_basic();
    int rv0;
    do_reset();
    rv0 = rv_seen;
    sw = 3'd5; load = 1'b1;
    repeat (PRESS_LAT - 1) tick();
    n_checks++; if (state !== 2'd0 || x !== 3'd0) begin n_fail++; $display("FAIL latency_early: state %0d x %0d want 0 0", state, x); end
    tick();
    model_press(3'd5);
    n_checks++; if (state !== 2'd1 || x !== 3'd5) begin n_fail++; $display("FAIL latency_land: state %0d x %0d want 1 5", state, x); end
    repeat (HOLD - PRESS_LAT) tick();
    load = 1'b0;
    repeat (4) tick();
    do_press(3'd3); model_press(3'd3);
    n_checks++; if (x !== m_x || y !== m_y || state !== 2'(m_state)) begin n_fail++; $display("FAIL basic_operands: x %0d y %0d st %0d want %0d %0d %0d", x, y, state, m_x, m_y, m_state); end
    n_checks++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL basic_op_valid: got %0b want 1", op_valid); end
    z_in = 4'd8; op_ready = 1'b1;
    tick();
    op_ready = 1'b0; model_capture(4'd8);
    n_checks++; if (state !== 2'(m_state) || result !== m_res || op_count !== 4'(m_cnt)) begin n_fail++; $display("FAIL basic_capture: st %0d res %0d cnt %0d want %0d %0d %0d", state, result, op_count, m_state, m_res, m_cnt); end
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rv_high: got %0b want 1", result_valid); end
    tick();
    n_checks++; if (result_valid !== 1'b0 || rv_seen - rv0 != 1) begin n_fail++; $display("FAIL basic_rv_once: rv %0b pulses %0d want 0 1", result_valid, rv_seen - rv0); end
    do_press(3'd7); model_press(3'd7);
    n_checks++; if (x !== m_x || y !== m_y || state !== 2'(m_state) || result !== m_res) begin n_fail++; $display("FAIL done_reload: x %0d y %0d st %0d res %0d want %0d %0d %0d %0d", x, y, state, result, m_x, m_y, m_state, m_res); end
  endtask

  task automatic test_held_load();
    do_reset();
    sw = 3'd4; load = 1'b1;
    repeat (20) tick();
    load = 1'b0;
    repeat (4) tick();
    model_press(3'd4);
    n_checks++; if (state !== 2'(m_state) || x !== m_x || y !== m_y) begin n_fail++; $display("FAIL held_single: st %0d x %0d y %0d want %0d %0d %0d", state, x, y, m_state, m_x, m_y); end
  endtask

  task automatic test_valid_hold();
    int rv0;
    logic [2:0] v;
    do_press(3'd1); model_press(3'd1);
    rv0 = rv_seen;
    op_ready = 1'b0; z_in = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      v = 3'($urandom);
      do_press(v); model_press(v);
    end
    n_checks++; if (x !== m_x || y !== m_y || op_valid !== 1'b1 || state !== 2'd2) begin n_fail++; $display("FAIL valid_hold: x %0d y %0d ov %0b st %0d want %0d %0d 1 2", x, y, op_valid, state, m_x, m_y); end
    n_checks++; if (rv_seen != rv0 || result !== m_res || op_count !== 4'(m_cnt)) begin n_fail++; $display("FAIL valid_no_capture: pulses %0d res %0d cnt %0d want 0 %0d %0d", rv_seen - rv0, result, op_count, m_res, m_cnt); end
  endtask

  task automatic test_clear_ready();
    int rv0;
    rv0 = rv_seen;
    z_in = 4'd6; clear = 1'b1; op_ready = 1'b1;
    tick();
    clear = 1'b0; op_ready = 1'b0; model_clear();
    tick();
    n_checks++; if (state !== 2'd0 || x !== 3'd0 || y !== 3'd0) begin n_fail++; $display("FAIL clear_ready_state: st %0d x %0d y %0d want 0 0 0", state, x, y); end
    n_checks++; if (result !== m_res || op_count !== 4'(m_cnt) || rv_seen != rv0) begin n_fail++; $display("FAIL clear_ready_keep: res %0d cnt %0d pulses %0d want %0d %0d 0", result, op_count, rv_seen - rv0, m_res, m_cnt); end
    sw = 3'd6; load = 1'b1;
    repeat (PRESS_LAT - 1) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (HOLD - PRESS_LAT) tick();
    load = 1'b0;
    repeat (4) tick();
    n_checks++; if (state !== 2'd0 || x !== 3'd0) begin n_fail++; $display("FAIL clear_press: st %0d x %0d want 0 0", state, x); end
  endtask

  task automatic test_random_wrap();
    int rv0, dly;
    logic [2:0] a, b;
    logic [3:0] z;
    do_reset();
    rv0 = rv_seen;
    for (int i = 0; i < 16; i++) begin
      a = 3'($urandom); b = 3'($urandom); z = 4'($urandom);
      do_press(a); model_press(a);
      do_press(b); model_press(b);
      dly = $urandom_range(0, 3);
      repeat (dly) tick();
      z_in = z; op_ready = 1'b1;
      tick();
      op_ready = 1'b0; model_capture(z);
      n_checks++; if (x !== m_x || y !== m_y || result !== m_res || op_count !== 4'(m_cnt) || state !== 2'(m_state)) begin
        n_fail++; $display("FAIL rand_op%0d: x %0d y %0d res %0d cnt %0d st %0d want %0d %0d %0d %0d %0d", i, x, y, result, op_count, state, m_x, m_y, m_res, m_cnt, m_state);
      end
    end
    tick();
    n_checks++; if (op_count !== 4'd0 || rv_seen - rv0 != 16) begin n_fail++; $display("FAIL wrap: cnt %0d pulses %0d want 0 16", op_count, rv_seen - rv0); end
  endtask

  task automatic test_bounce();
    logic [6:0]  pat;
    logic [11:0] rpat;
    logic [2:0]  v;
    int npulse, run;
    do_reset();
    pat = 7'b1111011;
    sw = 3'd2;
    npulse = 0; run = 0;
    for (int i = 0; i < 7; i++) begin
      load = pat[i];
      tick();
`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
      if (pat[i]) begin run++; if (run == DEB) npulse++; end else run = 0;
`else
      if (pat[i] && (i == 0 || !pat[i-1])) npulse++;
`endif
    end
    load = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < npulse; k++) model_press(3'd2);
    n_checks++; if (state !== 2'(m_state) || x !== m_x || y !== m_y) begin n_fail++; $display("FAIL bounce_fixed: st %0d x %0d y %0d want %0d %0d %0d", state, x, y, m_state, m_x, m_y); end
    for (int t = 0; t < 4; t++) begin
      clear = 1'b1; tick(); clear = 1'b0; model_clear();
      rpat = 12'($urandom);
      v = 3'($urandom);
      sw = v;
      npulse = 0; run = 0;
      for (int i = 0; i < 12; i++) begin
        load = rpat[i];
        tick();
`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
        if (rpat[i]) begin run++; if (run == DEB) npulse++; end else run = 0;
`else
        if (rpat[i] && (i == 0 || !rpat[i-1])) npulse++;
`endif
      end
      load = 1'b0;
      repeat (8) tick();
      for (int k = 0; k < npulse; k++) model_press(v);
      n_checks++; if (state !== 2'(m_state) || x !== m_x || y !== m_y) begin n_fail++; $display("FAIL bounce_rand%0d: pat %h st %0d x %0d y %0d want %0d %0d %0d", t, rpat, state, x, y, m_state, m_x, m_y); end
    end
  endtask

  task automatic test_reset_mid();
    int rv0;
    do_reset();
    do_press(3'd3);
    rv0 = rv_seen;
    rst = 1'b1; load = 1'b1; clear = 1'b1; op_ready = 1'b1;
    tick();
    model_reset();
    n_checks++; if (state !== 2'd0 || x !== 3'd0) begin n_fail++; $display("FAIL reset_mid_gotx: st %0d x %0d want 0 0", state, x); end
    rst = 1'b0; load = 1'b0; clear = 1'b0; op_ready = 1'b0;
    repeat (4) tick();
    do_press(3'd1); do_press(3'd2);
    z_in = 4'd9; rst = 1'b1; op_ready = 1'b1;
    tick();
    rst = 1'b0; op_ready = 1'b0;
    tick();
    n_checks++; if (state !== 2'd0 || result !== 4'd0 || op_count !== 4'd0 || y !== 3'd0 || rv_seen != rv0) begin
      n_fail++; $display("FAIL reset_mid_valid: st %0d res %0d cnt %0d y %0d pulses %0d want 0 0 0 0 0", state, result, op_count, y, rv_seen - rv0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_held_load();
    test_valid_hold();
    test_clear_ready();
    test_random_wrap();
    test_bounce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
